// File: rtl/lcd_pkg.sv
// Opcodes, issue-FSM states and helpers shared between the command sequencer
// and the LCD image controller.
package lcd_pkg;

  localparam logic [3:0] OP_WR  = 4'h0;
  localparam logic [3:0] OP_SU  = 4'h1;
  localparam logic [3:0] OP_SD  = 4'h2;
  localparam logic [3:0] OP_SL  = 4'h3;
  localparam logic [3:0] OP_SR  = 4'h4;
  localparam logic [3:0] OP_MAX = 4'h5;
  localparam logic [3:0] OP_MIN = 4'h6;
  localparam logic [3:0] OP_AVG = 4'h7;
  localparam logic [3:0] OP_CCR = 4'h8;
  localparam logic [3:0] OP_CR  = 4'h9;
  localparam logic [3:0] OP_MX  = 4'hA;
  localparam logic [3:0] OP_MY  = 4'hB;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_GUARD,
    ST_DRAIN,
    ST_FINISH
  } seq_state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    return op <= OP_MY;
  endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Small synchronous FIFO for 4-bit opcodes; pointers carry an extra wrap bit
// so full and empty fall straight out of a pointer compare.
module lcd_cmd_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [3:0] wdata,
  input  logic       pop,
  output logic [3:0] rdata,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [3:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// Host command front-end for the LCD controller: queues opcodes, drops illegal
// ones, and issues them one at a time with a guard cycle around controller busy.
module lcd_cmd_sequencer
  import lcd_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    host_cmd,
  input  logic          host_valid,
  output logic          host_ready,
  input  logic          lcd_busy,
  input  logic          lcd_done,
  output logic [3:0]    lcd_cmd,
  output logic          lcd_cmd_valid,
  output logic          seq_done,
  output logic          err_illegal,
  output logic [CW-1:0] cmd_count
);

  seq_state_t state;
  logic       full;
  logic       empty;
  logic [3:0] head;
  logic       accept;
  logic       push;
  logic       pop;
  logic       wr_seen;
  logic       wr_issued;
  logic       head_is_wr;

  // A full FIFO refuses input even on a pop cycle: no bypass path.
  assign host_ready = !full && !wr_seen;
  assign accept     = host_valid && host_ready;
  assign push       = accept && is_legal_op(host_cmd);
  assign pop        = (state == ST_IDLE) && !lcd_busy && !empty && !wr_issued;

  lcd_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (host_cmd),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_seen     <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      err_illegal <= accept && !is_legal_op(host_cmd);
      if (push && host_cmd == OP_WR) wr_seen <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      lcd_cmd       <= 4'h0;
      lcd_cmd_valid <= 1'b0;
      seq_done      <= 1'b0;
      cmd_count     <= '0;
      wr_issued     <= 1'b0;
      head_is_wr    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            lcd_cmd       <= head;
            lcd_cmd_valid <= 1'b1;
            head_is_wr    <= (head == OP_WR);
            if (cmd_count != '1) cmd_count <= cmd_count + 1'b1;
            state         <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // The controller decodes cmd in idle without looking at valid, so park it at 0.
          lcd_cmd       <= 4'h0;
          lcd_cmd_valid <= 1'b0;
          if (head_is_wr) begin
            wr_issued <= 1'b1;
            state     <= ST_DRAIN;
          end else begin
            state     <= ST_GUARD;
          end
        end
        ST_GUARD: state <= ST_IDLE;
        ST_DRAIN: begin
          if (lcd_done) begin
            seq_done <= 1'b1;
            state    <= ST_FINISH;
          end
        end
        ST_FINISH: state <= ST_FINISH;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/lcd_cmd_sequencer.md
# lcd_cmd_sequencer

Command front-end for the LCD image controller: buffers host commands in a small FIFO and issues them one at a time on the controller's `cmd`/`cmd_valid` port, honouring its `busy` handshake. It sits directly upstream of the controller, sanitises illegal opcodes and keeps the command bus at a harmless value between issues. After the terminal WRITE command (4'h0) it stops accepting input, waits for the controller's `done` and reports completion.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, at least 2.
- `CW`, 8: width of the issued-command counter.
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high
- `host_cmd`  in  4  opcode; 0=WR, 1=SU, 2=SD, 3=SL, 4=SR, 5=MAX, 6=MIN, 7=AVG, 8=CCR, 9=CR, A=MX, B=MY
- `host_valid`  in  1  host offers `host_cmd`
- `host_ready`  out  1  host transfer occurs on `host_valid && host_ready` at a rising edge
- `lcd_busy`  in  1  controller busy, straight from the controller
- `lcd_done`  in  1  controller image-write complete
- `lcd_cmd`  out  4  registered command to the controller
- `lcd_cmd_valid`  out  1  registered one-cycle issue strobe
- `seq_done`  out  1  sticky; set by `lcd_done` after WR was issued
- `err_illegal`  out  1  one-cycle pulse: opcode C–F accepted and dropped
- `cmd_count`  out  CW  commands issued, WR included; saturates at all-ones

## Operation
- **Reset values:** `lcd_cmd`=0, `lcd_cmd_valid`=0, `seq_done`=0, `err_illegal`=0, `cmd_count`=0; FIFO empty; `wr_seen`=0; state IDLE.
- **Host side:**
  - `host_ready = !full && !wr_seen`, combinational, with no pop bypass. A full FIFO refuses input even when a pop happens in the same cycle.
  - An accepted opcode C–F is not pushed; `err_illegal` pulses on the next cycle.
  - An accepted WR is pushed and sets `wr_seen`. All later input is refused until reset.
- **Issue FSM:**
  - IDLE: when `!lcd_busy && !empty && !wr_issued`, pop the head, register `lcd_cmd`=head, `lcd_cmd_valid`=1, increment `cmd_count`, then go to ISSUE.
  - ISSUE: one cycle. Clear the valid, set `lcd_cmd`=0, go to GUARD. If the head was WR, set `wr_issued` and go to DRAIN.
  - GUARD: one cycle; `lcd_busy` is ignored. Go to IDLE.
  - DRAIN: wait for `lcd_done`=1, then set `seq_done` and go to FINISH.
  - FINISH: terminal; outputs hold until reset.
- **Bus hygiene:** `lcd_cmd` must equal 4'h0 whenever `lcd_cmd_valid`=0. The controller acts on `cmd` in its idle state without qualifying it by `cmd_valid`, so a stale non-zero code there is a fault.
- **Start-up:** no issue while `lcd_busy`=1. This covers the 64+ cycle image load after reset.

## Timing
- **Issue timing:** edge E sets valid; E+1 clears it (controller samples on E+1 and enters OP). The GUARD cycle spans controller OP busy; at E+3 the FSM is back in IDLE.
- **Throughput:** the next valid rises no earlier than E+3, so at most one command per 3 cycles.
- **Latency:** host push to `lcd_cmd_valid` is at least 1 cycle, with empty FIFO and `lcd_busy`=0.
- **Done:** `seq_done` rises 1 cycle after `lcd_done` is sampled in DRAIN. `lcd_done` is ignored in any other state.
- **Reset:** asserting reset mid-operation returns everything to reset values immediately, with queued commands discarded. Deassertion is synchronised by the environment.

## Structure
- **Shared package `lcd_pkg`:**
  - 4-bit opcode constants WR..MY.
  - Issue-FSM state enum.
  - `is_legal_op` function.
  - Shared with the controller.
- **Sub-module `lcd_cmd_fifo`:**
  - Synchronous FIFO of width 4 and depth DEPTH.
  - Read/write pointers with an extra wrap bit; `full`/`empty` from the pointers.
  - Pop on an empty FIFO and push on a full FIFO are ignored.
- **Top:** host gating, FSM, counter and error pulse.

## Test plan
- **Reset/load:** hold `lcd_busy`=1 for 70 cycles and push SU. Expect no `lcd_cmd_valid` until the cycle after `lcd_busy` falls, then valid with `lcd_cmd`=1, and `cmd_count`=1.
- **Back-to-back:** push MAX, MIN, AVG with a behavioural controller model (busy 1 cycle after each valid). Expect valids exactly 3 cycles apart with codes 5, 6, 7, and `lcd_cmd`=0 in every non-valid cycle.
- **Full FIFO:**
  - With `lcd_busy` stuck at 1, push 9 commands. Expect `host_ready`=0 after 8 accepted; the 9th is held by the host.
  - Release busy. Expect the 8 commands issued in order.
- **Illegal opcode:** push SR, E, SL. Expect `err_illegal` to pulse once, issues 4 then 3, and `cmd_count`=2.
- **Terminal WR:**
  - Push MX, WR, SD. Expect SD refused (`host_ready`=0 after WR) and issues A then 0.
  - Then pulse `lcd_done` 40 cycles later. Expect `seq_done`=1 the following cycle, sticky, and `cmd_count`=2.
- **Mid-run reset:** with 5 queued commands, assert reset while in GUARD. Expect all outputs at reset values, FIFO empty, and no further issues.
